// File: rtl/sync_burst_gen.sv
// sync_burst_gen: two-stage (wake-up, then comparator sync) burst transmitter.
// A wake_up edge arms the block for a bounded time. A comp_out rising edge
// then starts a burst of preamble zeros, payload bits (optionally scrambled)
// and tail zeros. Each bit lasts DIV clocks, and data_clk rises mid-bit.
//
// Handshake/timing contract: wake_up and comp_out are asynchronous levels.
// Only their synchronized rising edges matter, and each edge is acted on only
// in the state that expects it. abort is synchronous and wins over
// everything else. done and timeout are single-cycle pulses.
module sync_burst_gen #(
  parameter int DIV          = 100,
  parameter int PRE_LEN      = 432,
  parameter int PAY_LEN      = 768,
  parameter int TAIL_LEN     = 16,
  parameter int SYNC_TIMEOUT = 20000,
  parameter int CNT_W        = 20
) (
  input  logic             clki,
  input  logic             rst_n,
  input  logic             wake_up,
  input  logic             comp_out,
  input  logic             scr_en,
  input  logic             abort,
  output logic             wu_valid,
  output logic             data_clk_enb,
  output logic             data_clk,
  output logic             t_out,
  output logic [CNT_W-1:0] bit_idx,
  output logic             done,
  output logic             timeout,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_TX    = 2'd2;

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] DIV_HALF   = CNT_W'(DIV / 2);
  localparam logic [CNT_W-1:0] PAY_START  = CNT_W'(PRE_LEN);
  localparam logic [CNT_W-1:0] TAIL_START = CNT_W'(PRE_LEN + PAY_LEN);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(PRE_LEN + PAY_LEN + TAIL_LEN - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(SYNC_TIMEOUT - 1);

  logic [2:0]       wu_sr;
  logic [2:0]       cmp_sr;
  logic [1:0]       state;
  logic [CNT_W-1:0] tmo_cnt;
  logic [CNT_W-1:0] phase;
  logic             scr_lat;
  logic [7:0]       scr_s;

  logic             wu_rise;
  logic             sync_rise;
  logic             start_tx;
  logic             load_bit;
  logic [CNT_W-1:0] load_idx;
  logic [7:0]       load_s;
  logic             load_scr;
  logic             is_pay;
  logic [2:0]       pay_lo;
  logic             raw_d;
  logic             next_bit;
  logic [CNT_W-1:0] phase_nxt;

  assign wu_valid     = (state == ST_ARMED);
  assign data_clk_enb = (state == ST_TX);
  assign state_dbg    = state;

  // Edge detection on synchronized inputs, plus the value of the next bit to drive.
  // The next bit is either bit 0 (on TX entry, with the scrambler cleared)
  // or bit_idx+1 (at the end of a bit).
  always_comb begin
    wu_rise   = (wu_sr[2:1] == 2'b01);
    sync_rise = (cmp_sr[2:1] == 2'b01);
    start_tx  = (state == ST_ARMED) && sync_rise;
    load_bit  = start_tx ||
                ((state == ST_TX) && (phase == DIV_LAST) && (bit_idx != BIT_LAST));
    load_idx  = start_tx ? '0 : (bit_idx + CNT_W'(1));
    load_s    = start_tx ? 8'd0 : scr_s;
    load_scr  = start_tx ? scr_en : scr_lat;
    is_pay    = (load_idx >= PAY_START) && (load_idx < TAIL_START);
    // Payload index mod 8 only needs the low three bits of the subtraction.
    pay_lo    = load_idx[2:0] - PAY_START[2:0];
    raw_d     = (pay_lo < 3'd4);
    next_bit  = 1'b0;
    if (is_pay) begin
      if (load_scr) begin
        next_bit = raw_d ^ load_s[0] ^ load_s[3] ^ load_s[4] ^ load_s[6] ^ load_s[7];
      end else begin
        next_bit = raw_d;
      end
    end
    phase_nxt = phase + CNT_W'(1);
  end

  // Synchronizers, FSM, bit timing and the serial output register.
  always_ff @(posedge clki) begin
    if (!rst_n) begin
      wu_sr    <= '0;
      cmp_sr   <= '0;
      state    <= ST_IDLE;
      tmo_cnt  <= '0;
      phase    <= '0;
      bit_idx  <= '0;
      scr_lat  <= 1'b0;
      scr_s    <= '0;
      t_out    <= 1'b0;
      data_clk <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      wu_sr   <= {wu_sr[1:0], wake_up};
      cmp_sr  <= {cmp_sr[1:0], comp_out};
      done    <= 1'b0;
      timeout <= 1'b0;
      if (abort) begin
        state    <= ST_IDLE;
        tmo_cnt  <= '0;
        phase    <= '0;
        bit_idx  <= '0;
        t_out    <= 1'b0;
        data_clk <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (wu_rise) begin
              state   <= ST_ARMED;
              tmo_cnt <= '0;
            end
          end
          ST_ARMED: begin
            // A sync edge in the expiry cycle still starts the burst.
            if (sync_rise) begin
              state    <= ST_TX;
              phase    <= '0;
              bit_idx  <= '0;
              scr_lat  <= scr_en;
              scr_s    <= '0;
              data_clk <= 1'b0;
            end else if (tmo_cnt == TMO_LAST) begin
              state   <= ST_IDLE;
              timeout <= 1'b1;
            end else begin
              tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
          end
          ST_TX: begin
            if (phase == DIV_LAST) begin
              phase    <= '0;
              data_clk <= 1'b0;
              if (bit_idx == BIT_LAST) begin
                state   <= ST_IDLE;
                done    <= 1'b1;
                bit_idx <= '0;
                t_out   <= 1'b0;
              end else begin
                bit_idx <= bit_idx + CNT_W'(1);
              end
            end else begin
              phase    <= phase_nxt;
              data_clk <= (phase_nxt >= DIV_HALF);
            end
          end
          default: state <= ST_IDLE;
        endcase
        if (load_bit) begin
          t_out <= next_bit;
          if (is_pay && load_scr) begin
            scr_s <= {load_s[6:0], next_bit};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_burst_gen.sv
// Directed testbench for sync_burst_gen with small burst parameters.
// Inputs are driven on the falling edge and outputs are sampled on the falling edge.
module tb_sync_burst_gen;

  localparam int CNT_W = 20;

  logic             clki = 1'b0;
  logic             rst_n;
  logic             wake_up;
  logic             comp_out;
  logic             scr_en;
  logic             abort;
  logic             wu_valid;
  logic             data_clk_enb;
  logic             data_clk;
  logic             t_out;
  logic [CNT_W-1:0] bit_idx;
  logic             done;
  logic             timeout;
  logic [1:0]       state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [0:0] exp_q[$];

  sync_burst_gen #(
    .DIV(4), .PRE_LEN(4), .PAY_LEN(8), .TAIL_LEN(2), .SYNC_TIMEOUT(20), .CNT_W(CNT_W)
  ) dut (
    .clki(clki), .rst_n(rst_n), .wake_up(wake_up), .comp_out(comp_out),
    .scr_en(scr_en), .abort(abort), .wu_valid(wu_valid), .data_clk_enb(data_clk_enb),
    .data_clk(data_clk), .t_out(t_out), .bit_idx(bit_idx), .done(done),
    .timeout(timeout), .state_dbg(state_dbg)
  );

  // Clock and watchdog
  always #5 clki = ~clki;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000ns");
    $fatal(1);
  end

  // Single comparison point
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Raise wake_up at a falling edge; ARMED must appear on the third falling edge.
  task automatic arm();
    wake_up = 1'b1;
    @(negedge clki);
    @(negedge clki);
    check("arm_not_yet", 32'(wu_valid), 32'd0);
    @(negedge clki);
    check("arm_lat", 32'(wu_valid), 32'd1);
    check("arm_state", 32'(state_dbg), 32'd1);
    wake_up = 1'b0;
  endtask

  // Raise comp_out while ARMED; TX must appear on the third falling edge.
  task automatic sync_start();
    comp_out = 1'b1;
    @(negedge clki);
    @(negedge clki);
    check("sync_not_yet", 32'(data_clk_enb), 32'd0);
    @(negedge clki);
    check("sync_lat", 32'(data_clk_enb), 32'd1);
  endtask

  // Walk a full burst from its first TX cycle; pat holds bit 0 in its MSB.
  task automatic tx_check(input logic [13:0] pat, input bit poke, input bit early_wake);
    logic [0:0] exp_bit;
    exp_bit = 1'b0;
    for (int k = 0; k < 14; k++) exp_q.push_back(pat[13-k]);
    for (int c = 0; c < 56; c++) begin
      if (c % 4 == 0) exp_bit = exp_q.pop_front();
      check("t_out", 32'(t_out), 32'(exp_bit));
      check("data_clk", 32'(data_clk), 32'((c % 4) >= 2));
      check("bit_idx", 32'(bit_idx), 32'(c / 4));
      check("tx_enb", 32'(data_clk_enb), 32'd1);
      check("no_early_done", 32'(done), 32'd0);
      if (c == 2) comp_out = 1'b0;
      if (poke && c == 10) begin wake_up = 1'b1; comp_out = 1'b1; end
      if (poke && c == 14) begin wake_up = 1'b0; comp_out = 1'b0; end
      if (early_wake && c == 54) wake_up = 1'b1;
      @(negedge clki);
    end
    check("end_enb", 32'(data_clk_enb), 32'd0);
    check("done_pulse", 32'(done), 32'd1);
    check("end_t_out", 32'(t_out), 32'd0);
    check("end_bit_idx", 32'(bit_idx), 32'd0);
    check("end_state", 32'(state_dbg), 32'd0);
    wake_up = 1'b0;
    @(negedge clki);
    check("done_one_cycle", 32'(done), 32'd0);
    check("after_done_armed", 32'(wu_valid), 32'(early_wake));
  endtask

  // Stimulus and summary
  initial begin
    int cnt;
    int pulses;
    rst_n = 1'b0; wake_up = 1'b0; comp_out = 1'b0; scr_en = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clki);
    check("rst_wu_valid", 32'(wu_valid), 32'd0);
    check("rst_enb", 32'(data_clk_enb), 32'd0);
    check("rst_t_out", 32'(t_out), 32'd0);
    check("rst_bit_idx", 32'(bit_idx), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    rst_n = 1'b1;
    @(negedge clki);

    // comp_out edge in IDLE is ignored
    comp_out = 1'b1;
    repeat (2) @(negedge clki);
    comp_out = 1'b0;
    repeat (4) @(negedge clki);
    check("idle_comp_ignored", 32'(state_dbg), 32'd0);

    // Plain burst
    scr_en = 1'b0;
    arm();
    sync_start();
    scr_en = 1'b1;   // latched value must hold for the burst
    tx_check(14'b0000_11110000_00, 1'b0, 1'b0);

    // Scrambled burst, with wake_up timed to be accepted right after done
    scr_en = 1'b1;
    arm();
    sync_start();
    scr_en = 1'b0;
    tx_check(14'b0000_10101011_00, 1'b0, 1'b1);
    abort = 1'b1;
    @(negedge clki);
    abort = 1'b0;
    check("abort_armed_idle", 32'(state_dbg), 32'd0);
    check("abort_no_timeout", 32'(timeout), 32'd0);

    // Timeout: ARMED lasts exactly 20 cycles
    arm();
    cnt = 0;
    while (wu_valid && cnt < 100) begin
      cnt++;
      @(negedge clki);
    end
    check("armed_cycles", 32'(cnt), 32'd20);
    check("timeout_pulse", 32'(timeout), 32'd1);
    check("timeout_idle", 32'(state_dbg), 32'd0);
    @(negedge clki);
    check("timeout_one_cycle", 32'(timeout), 32'd0);
    comp_out = 1'b1;
    repeat (3) @(negedge clki);
    comp_out = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (data_clk_enb) pulses++;
      @(negedge clki);
    end
    check("no_tx_after_timeout", 32'(pulses), 32'd0);

    // Sync edge lands in the expiry cycle; pokes during TX are ignored
    scr_en = 1'b0;
    arm();
    repeat (17) @(negedge clki);
    comp_out = 1'b1;
    @(negedge clki);
    @(negedge clki);
    check("expiry_still_armed", 32'(wu_valid), 32'd1);
    @(negedge clki);
    check("expiry_sync_tx", 32'(data_clk_enb), 32'd1);
    check("expiry_no_timeout", 32'(timeout), 32'd0);
    tx_check(14'b0000_11110000_00, 1'b1, 1'b0);

    // Abort at bit 6
    arm();
    sync_start();
    repeat (24) @(negedge clki);
    comp_out = 1'b0;
    check("abort_at_bit", 32'(bit_idx), 32'd6);
    abort = 1'b1;
    @(negedge clki);
    abort = 1'b0;
    check("abort_idle", 32'(state_dbg), 32'd0);
    check("abort_enb", 32'(data_clk_enb), 32'd0);
    check("abort_bit_idx", 32'(bit_idx), 32'd0);
    check("abort_t_out", 32'(t_out), 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) pulses++;
      @(negedge clki);
    end
    check("abort_no_done", 32'(pulses), 32'd0);

    // Reset while ARMED
    arm();
    rst_n = 1'b0;
    @(negedge clki);
    check("rst_armed_wu_valid", 32'(wu_valid), 32'd0);
    check("rst_armed_enb", 32'(data_clk_enb), 32'd0);
    check("rst_armed_data_clk", 32'(data_clk), 32'd0);
    check("rst_armed_t_out", 32'(t_out), 32'd0);
    check("rst_armed_bit_idx", 32'(bit_idx), 32'd0);
    check("rst_armed_done", 32'(done), 32'd0);
    check("rst_armed_timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;
    @(negedge clki);

    // Recovery burst after reset
    scr_en = 1'b1;
    arm();
    sync_start();
    tx_check(14'b0000_10101011_00, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sync_burst_gen.md
SYNC_BURST_GEN -- requirements
Module: sync_burst_gen

Interface
REQ-001 Parameter DIV, default 100; system clocks per data bit; even, at least 4.
REQ-002 Parameter PRE_LEN, default 432; number of preamble bits, all 0.
REQ-003 Parameter PAY_LEN, default 768; number of payload bits.
REQ-004 Parameter TAIL_LEN, default 16; number of tail bits, all 0.
REQ-005 Parameter SYNC_TIMEOUT, default 20000; maximum clki cycles spent in ARMED waiting for sync.
REQ-006 Parameter CNT_W, default 20; width of bit_idx and internal counters; it SHALL hold PRE_LEN+PAY_LEN+TAIL_LEN, DIV and SYNC_TIMEOUT.
REQ-007 clki  in  1  single system clock; all logic on its rising edge.
REQ-008 rst_n  in  1  reset; synchronous, active-low.
REQ-009 wake_up  in  1  asynchronous wake-up request (stage 1).
REQ-010 comp_out  in  1  asynchronous comparator output; its rising edge is the sync event (stage 2).
REQ-011 scr_en  in  1  scrambler enable for payload bits.
REQ-012 abort  in  1  synchronous abort; returns the block to IDLE.
REQ-013 wu_valid  out  1  high while in ARMED.
REQ-014 data_clk_enb  out  1  high while in TX.
REQ-015 data_clk  out  1  bit clock, registered level, not used as a clock internally.
REQ-016 t_out  out  1  serial transmit bit.
REQ-017 bit_idx  out  CNT_W  index of the current bit in TX.
REQ-018 done  out  1  one-cycle pulse when a burst completes.
REQ-019 timeout  out  1  one-cycle pulse when ARMED expires.

Function
REQ-020 wake_up and comp_out SHALL each pass through a 3-flop shift register; a rising edge is flop[2:1]==01. Input first sampled high at edge n -> state change registered at edge n+2.
REQ-021 The FSM SHALL have the states IDLE, ARMED and TX.
REQ-022 IDLE -> ARMED on a wake_up rising edge. The timeout counter clears to 0 on entry.
REQ-023 In ARMED, the timeout counter SHALL increment once per cycle.
REQ-024 A comp_out rising edge in ARMED SHALL cause a transition to TX.
REQ-025 If the counter reaches SYNC_TIMEOUT-1 with no sync edge, timeout SHALL pulse and the FSM SHALL return to IDLE.
REQ-026 If a sync edge and expiry occur in the same cycle, the sync edge SHALL win and no timeout pulse SHALL occur.
REQ-027 A comp_out edge in IDLE SHALL be ignored.
REQ-028 A wake_up edge in ARMED or TX SHALL be ignored; it SHALL neither re-arm nor restart the counter.
REQ-029 On TX entry: bit_idx=0, phase counter=0, and scr_en latched for the whole burst.
REQ-030 Each bit SHALL last exactly DIV cycles.
REQ-031 data_clk SHALL be 0 for phase 0..DIV/2-1 and 1 for phase DIV/2..DIV-1, giving a mid-bit rising edge.
REQ-032 At phase DIV-1, bit_idx SHALL increment, phase SHALL wrap to 0, and t_out SHALL update to the next bit in the same cycle.
REQ-033 t_out SHALL be valid for bit k for all DIV cycles of that bit, starting in the first TX cycle.
REQ-034 Bit k SHALL be a preamble bit for k<PRE_LEN, a payload bit for k<PRE_LEN+PAY_LEN, and a tail bit otherwise. Preamble and tail bits SHALL be 0.
REQ-035 The payload raw bit d for payload index j SHALL be 1 when (j mod 8)<4, else 0.
REQ-036 When the latched scr_en is 0, t_out SHALL equal d.
REQ-037 When the latched scr_en is 1, s[7:0] SHALL be cleared at TX entry, with s[0] the most recent payload output bit.
REQ-038 With scrambling on, each payload bit SHALL be out = d^s[0]^s[3]^s[4]^s[6]^s[7], after which s <= {s[6:0],out}.
REQ-039 After the last phase of bit N-1 (N=PRE_LEN+PAY_LEN+TAIL_LEN), done SHALL pulse and the FSM SHALL enter IDLE. Outputs then return to idle values.
REQ-040 abort SHALL force IDLE in the next cycle from any state, with no done or timeout pulse; abort has priority over all other transitions.
REQ-041 A new wake_up edge SHALL be accepted in the first IDLE cycle after done.

Reset
REQ-042 While rst_n=0 at a clki edge: FSM=IDLE, all counters, synchronizers and s=0.
REQ-043 While rst_n=0 at a clki edge: wu_valid, data_clk_enb, data_clk, t_out, done and timeout = 0, and bit_idx=0.
REQ-044 Reset asserted mid-burst SHALL terminate the burst without a done pulse.

Verification
REQ-045 Test parameters: DIV=4, PRE_LEN=4, PAY_LEN=8, TAIL_LEN=2, SYNC_TIMEOUT=20.
REQ-046 wake_up then comp_out rise, scr_en=0 -> t_out per bit = 0000 11110000 00, 56 TX cycles, then done pulses once.
REQ-047 Same as REQ-046 with scr_en=1 -> payload t_out = 1,0,1,0,1,0,1,1.
REQ-048 wake_up only -> wu_valid high exactly 20 cycles, then timeout pulses and FSM returns to IDLE; a later comp_out rise produces no TX.
REQ-049 Sync edge in the expiry cycle -> TX entered, no timeout pulse; extra wake_up and comp_out pulses during TX -> burst unchanged.
REQ-050 abort at bit 6 -> IDLE next cycle, no done; rst_n low in ARMED -> all outputs 0 next edge.
